// File: rtl/logic_fetch.sv
// logic_fetch: reads a frame of NUM_WORDS memory words starting at a base
// address and serialises each word into NUM_PE-bit cell beats, LSB first.
// A one-word prefetch register hides read latency so that consecutive words
// stream without a gap whenever the prefetch is already full at a word end.
// WORD_SIZE must be an exact multiple of NUM_PE with at least two beats per word.

module logic_fetch #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_PE     = 1,
  parameter int NUM_WORDS  = 9600,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  stall_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] addr_r_out,
  input  logic [WORD_SIZE-1:0]  data_r_in,
  output logic [NUM_PE-1:0]     cell_out,
  output logic                  cell_valid_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int BEATS = WORD_SIZE / NUM_PE;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_en_q;
  logic                  pend_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         loaded_q;
  logic [BW-1:0]         beat_q;
  logic [WORD_SIZE-1:0]  shift_q;
  logic [WORD_SIZE-1:0]  pf_q;
  logic                  pf_full_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  consume_d;
  logic                  word_end_d;
  logic                  final_word_d;
  logic                  issue_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // A beat leaves the shift register whenever it is valid and not stalled;
  // the frame ends when the last beat of the final loaded word goes out.
  assign consume_d    = valid_q & ~stall_in;
  assign word_end_d   = consume_d & (beat_q == BW'(BEATS - 1));
  assign final_word_d = (loaded_q == CW'(NUM_WORDS));

  // Only one read may be outstanding, and only when the prefetch slot is free.
  assign issue_d = (state_q == STREAM) & ~pf_full_q & ~rd_en_q & ~pend_q &
                   (issued_q < CW'(NUM_WORDS));
  assign addr_d  = base_q + ADDR_WIDTH'(issued_q);

  assign rd_en_out      = rd_en_q;
  assign addr_r_out     = addr_q;
  assign cell_out       = shift_q[NUM_PE-1:0];
  assign cell_valid_out = valid_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;

  // Frame sequencer: read issue, prefetch capture, beat shifting and frame end.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      pend_q    <= 1'b0;
      issued_q  <= '0;
      loaded_q  <= '0;
      beat_q    <= '0;
      shift_q   <= '0;
      pf_q      <= '0;
      pf_full_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      pend_q  <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            base_q    <= base_addr_in;
            addr_q    <= base_addr_in;
            rd_en_q   <= 1'b1;
            issued_q  <= CW'(1);
            loaded_q  <= '0;
            beat_q    <= '0;
            pf_full_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= PRIME;
          end
        end
        PRIME: begin
          if (pend_q) begin
            shift_q  <= data_r_in;
            beat_q   <= '0;
            valid_q  <= 1'b1;
            loaded_q <= CW'(1);
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (issue_d) begin
            rd_en_q  <= 1'b1;
            addr_q   <= addr_d;
            issued_q <= issued_q + CW'(1);
          end
          if (word_end_d && final_word_d) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (word_end_d || !valid_q) begin
            if (pf_full_q) begin
              shift_q   <= pf_q;
              pf_full_q <= 1'b0;
              beat_q    <= '0;
              valid_q   <= 1'b1;
              loaded_q  <= loaded_q + CW'(1);
            end else if (pend_q) begin
              shift_q  <= data_r_in;
              beat_q   <= '0;
              valid_q  <= 1'b1;
              loaded_q <= loaded_q + CW'(1);
            end else begin
              valid_q <= 1'b0;
            end
          end else begin
            if (consume_d) begin
              shift_q <= shift_q >> NUM_PE;
              beat_q  <= beat_q + BW'(1);
            end
            if (pend_q) begin
              pf_q      <= data_r_in;
              pf_full_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_fetch.sv
// tb_logic_fetch: directed scenarios for logic_fetch across three parameter
// sets (bit-serial frame, 3-bit address wrap, 4-bit cells).

module tb_logic_fetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        startA, stallA, rdA, validA, busyA, doneA;
  logic [13:0] baseA, addrA;
  logic [7:0]  dataA;
  logic [0:0]  cellA;

  logic        startB, stallB, rdB, validB, busyB, doneB;
  logic [2:0]  baseB, addrB;
  logic [7:0]  dataB;
  logic [0:0]  cellB;

  logic        startC, stallC, rdC, validC, busyC, doneC;
  logic [3:0]  baseC, addrC;
  logic [7:0]  dataC;
  logic [3:0]  cellC;

  logic_fetch #(.WORD_SIZE(8), .NUM_PE(1), .NUM_WORDS(3), .ADDR_WIDTH(14)) dutA (
    .clk_in(clk), .rst_in(rst), .start_in(startA), .stall_in(stallA),
    .base_addr_in(baseA), .rd_en_out(rdA), .addr_r_out(addrA), .data_r_in(dataA),
    .cell_out(cellA), .cell_valid_out(validA), .busy_out(busyA), .done_out(doneA));

  logic_fetch #(.WORD_SIZE(8), .NUM_PE(1), .NUM_WORDS(2), .ADDR_WIDTH(3)) dutB (
    .clk_in(clk), .rst_in(rst), .start_in(startB), .stall_in(stallB),
    .base_addr_in(baseB), .rd_en_out(rdB), .addr_r_out(addrB), .data_r_in(dataB),
    .cell_out(cellB), .cell_valid_out(validB), .busy_out(busyB), .done_out(doneB));

  logic_fetch #(.WORD_SIZE(8), .NUM_PE(4), .NUM_WORDS(2), .ADDR_WIDTH(4)) dutC (
    .clk_in(clk), .rst_in(rst), .start_in(startC), .stall_in(stallC),
    .base_addr_in(baseC), .rd_en_out(rdC), .addr_r_out(addrC), .data_r_in(dataC),
    .cell_out(cellC), .cell_valid_out(validC), .busy_out(busyC), .done_out(doneC));

  int errors = 0;
  int checks = 0;

  logic [13:0] readsA[$];
  logic [2:0]  readsB[$];
  logic        bitsA[$];

  int doneCnt, doneAtBits, gapCnt, holdBad;
  bit busyAtDone, validAtDone, timedOut;

  // Memory contents for the main instance.
  function automatic logic [7:0] memA(input logic [13:0] a);
    case (a)
      14'd5:   return 8'hA5;
      14'd6:   return 8'h3C;
      14'd7:   return 8'hFF;
      default: return a[7:0] ^ 8'h69;
    endcase
  endfunction

  // Synchronous memories: data appears the cycle after the read strobe; reads are logged.
  always @(posedge clk) begin
    dataA <= rdA ? memA(addrA) : 8'h00;
    dataB <= rdB ? ({5'd0, addrB} ^ 8'hC3) : 8'h00;
    dataC <= rdC ? ((addrC == 4'd0) ? 8'hA5 : ((addrC == 4'd1) ? 8'h3C : 8'h00)) : 8'h00;
    if (rdA) readsA.push_back(addrA);
    if (rdB) readsB.push_back(addrB);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 24-bit LSB-first stream of a three-word frame at base.
  function automatic logic [23:0] expStream(input logic [13:0] base);
    logic [23:0] e;
    logic [7:0]  w;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      w = memA(base + 14'(k));
      for (int b = 0; b < 8; b++) e[k*8+b] = w[b];
    end
    return e;
  endfunction

  function automatic logic [23:0] gotStream();
    logic [23:0] g;
    g = '0;
    for (int i = 0; i < 24 && i < bitsA.size(); i++) g[i] = bitsA[i];
    return g;
  endfunction

  // Runs one frame on dutA, recording beats, stall hold violations and the done pulse.
  task automatic collectFrame(input logic [13:0] base, input bit doStart, input int s1,
                              input int s2, input int stallLen, input int midStartAt,
                              input bit restartAtDone, input logic [13:0] base2);
    int  st1 = 0, st2 = 0, post = 0;
    bit  prevStall = 0, doneSeen = 0, midDone = 0;
    logic heldCell = 1'b0;
    bitsA.delete();
    doneCnt = 0; doneAtBits = -1; busyAtDone = 1; validAtDone = 1;
    gapCnt = 0; holdBad = 0; timedOut = 0;
    if (doStart) begin
      baseA = base; startA = 1'b1; tick(); startA = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (doneSeen) begin
        startA = 1'b0;
        if (doneA) doneCnt++;
        post++;
        if (post == 2) break;
        tick();
        continue;
      end
      startA = 1'b0;
      if (prevStall && (cellA !== heldCell || validA !== 1'b1)) holdBad++;
      if (doneA) begin
        doneCnt++; doneSeen = 1; doneAtBits = bitsA.size();
        busyAtDone = busyA; validAtDone = validA; stallA = 1'b0;
        if (restartAtDone) begin baseA = base2; startA = 1'b1; end
        tick();
        continue;
      end
      if (midStartAt >= 0 && validA && bitsA.size() == midStartAt && !midDone) begin
        baseA = 14'd0; startA = 1'b1; midDone = 1;
      end
      stallA = 1'b0;
      if (validA && bitsA.size() == s1 && st1 < stallLen) begin
        stallA = 1'b1; st1++;
      end else if (validA && bitsA.size() == s2 && st2 < stallLen) begin
        stallA = 1'b1; st2++;
      end
      prevStall = stallA;
      heldCell = cellA[0];
      if (validA && !stallA) bitsA.push_back(cellA[0]);
      if (!validA && bitsA.size() > 0) gapCnt++;
      tick();
    end
    if (!doneSeen) timedOut = 1;
    stallA = 1'b0;
    startA = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    startA = 0; stallA = 0; baseA = '0;
    startB = 0; stallB = 0; baseB = '0;
    startC = 0; stallC = 0; baseC = '0;
    #1;
    checks++;
    if ({rdA, addrA, cellA, validA, busyA, doneA} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs_A got=%h want=0", {rdA, addrA, cellA, validA, busyA, doneA});
    end
    checks++;
    if ({rdB, addrB, cellB, validB, busyB, doneB, rdC, addrC, cellC, validC, busyC, doneC} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs_BC got=%h want=0",
                         {rdB, addrB, cellB, validB, busyB, doneB, rdC, addrC, cellC, validC, busyC, doneC});
    end
    startA = 1'b1; baseA = 14'd9;
    tick(); tick();
    startA = 1'b0;
    checks++;
    if ({rdA, busyA, validA} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_beats_start got=%b want=000", {rdA, busyA, validA});
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({rdA, busyA} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_release_idle got=%b want=00", {rdA, busyA});
    end
  endtask

  task automatic test_basic();
    readsA.delete();
    collectFrame(14'd5, 1, -1, -1, 0, -1, 0, 14'd0);
    checks++;
    if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout got=no_done want=done"); end
    checks++;
    if (gotStream() !== expStream(14'd5) || bitsA.size() != 24) begin
      errors++; $display("[TB] FAIL basic_stream got=%h/%0d want=%h/24", gotStream(), bitsA.size(), expStream(14'd5));
    end
    checks++;
    if (readsA.size() != 3 || readsA[0] !== 14'd5 || readsA[1] !== 14'd6 || readsA[2] !== 14'd7) begin
      errors++; $display("[TB] FAIL basic_reads got=%0d reads want=5,6,7", readsA.size());
    end
    checks++;
    if (gapCnt != 0) begin errors++; $display("[TB] FAIL basic_contiguous got=%0d gaps want=0", gapCnt); end
    checks++;
    if (doneCnt != 1 || doneAtBits != 24) begin
      errors++; $display("[TB] FAIL basic_done got=%0d pulses at beat %0d want=1 at 24", doneCnt, doneAtBits);
    end
    checks++;
    if (busyAtDone !== 1'b0 || validAtDone !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_done_flags got=busy%b valid%b want=busy0 valid0", busyAtDone, validAtDone);
    end
  endtask

  task automatic test_stall();
    readsA.delete();
    collectFrame(14'd5, 1, 4, 7, 3, -1, 0, 14'd0);
    checks++;
    if (gotStream() !== expStream(14'd5) || bitsA.size() != 24) begin
      errors++; $display("[TB] FAIL stall_stream got=%h/%0d want=%h/24", gotStream(), bitsA.size(), expStream(14'd5));
    end
    checks++;
    if (holdBad != 0) begin errors++; $display("[TB] FAIL stall_hold got=%0d violations want=0", holdBad); end
    checks++;
    if (readsA.size() != 3) begin errors++; $display("[TB] FAIL stall_reads got=%0d want=3", readsA.size()); end
    checks++;
    if (doneCnt != 1 || timedOut) begin errors++; $display("[TB] FAIL stall_done got=%0d want=1", doneCnt); end
  endtask

  task automatic test_busy_start();
    readsA.delete();
    collectFrame(14'd5, 1, -1, -1, 0, 10, 0, 14'd0);
    checks++;
    if (readsA.size() != 3 || readsA[0] !== 14'd5 || readsA[2] !== 14'd7) begin
      errors++; $display("[TB] FAIL busy_start_reads got=%0d want=3 at 5..7", readsA.size());
    end
    checks++;
    if (gotStream() !== expStream(14'd5) || doneCnt != 1) begin
      errors++; $display("[TB] FAIL busy_start_stream got=%h done=%0d want=%h done=1", gotStream(), doneCnt, expStream(14'd5));
    end
  endtask

  task automatic test_back_to_back();
    readsA.delete();
    collectFrame(14'd5, 1, -1, -1, 0, -1, 1, 14'd20);
    checks++;
    if (gotStream() !== expStream(14'd5) || doneCnt != 1) begin
      errors++; $display("[TB] FAIL b2b_first got=%h done=%0d want=%h done=1", gotStream(), doneCnt, expStream(14'd5));
    end
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got=busy%b want=busy1", busyA); end
    collectFrame(14'd0, 0, -1, -1, 0, -1, 0, 14'd0);
    checks++;
    if (gotStream() !== expStream(14'd20) || doneCnt != 1) begin
      errors++; $display("[TB] FAIL b2b_second got=%h done=%0d want=%h done=1", gotStream(), doneCnt, expStream(14'd20));
    end
    checks++;
    if (readsA.size() != 6 || readsA[3] !== 14'd20 || readsA[5] !== 14'd22) begin
      errors++; $display("[TB] FAIL b2b_reads got=%0d want=6 ending 20..22", readsA.size());
    end
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    readsA.delete();
    baseA = 14'd5; startA = 1'b1; tick(); startA = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (rdA !== 1'b1 || addrA !== 14'd6) begin
      errors++; $display("[TB] FAIL midreset_prefetch_issue got=rd%b addr%0d want=rd1 addr6", rdA, addrA);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({rdA, addrA, cellA, validA, busyA, doneA} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs got=%h want=0", {rdA, addrA, cellA, validA, busyA, doneA});
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (validA !== 1'b0 || busyA !== 1'b0 || rdA !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL midreset_discard got=%0d active cycles want=0", bad); end
    readsA.delete();
    collectFrame(14'd20, 1, -1, -1, 0, -1, 0, 14'd0);
    checks++;
    if (gotStream() !== expStream(14'd20) || readsA.size() != 3 || readsA[0] !== 14'd20) begin
      errors++; $display("[TB] FAIL midreset_restart got=%h reads=%0d want=%h reads=3", gotStream(), readsA.size(), expStream(14'd20));
    end
  endtask

  task automatic test_wrap();
    int  beats = 0;
    bit  seen = 0;
    readsB.delete();
    baseB = 3'd7; startB = 1'b1; tick(); startB = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (doneB) begin seen = 1; break; end
      if (validB) beats++;
      tick();
    end
    checks++;
    if (!seen || beats != 16) begin
      errors++; $display("[TB] FAIL wrap_frame got=done%0d beats%0d want=done1 beats16", seen, beats);
    end
    checks++;
    if (readsB.size() != 2 || readsB[0] !== 3'd7 || readsB[1] !== 3'd0) begin
      errors++; $display("[TB] FAIL wrap_addr got=%0d reads want=7,0", readsB.size());
    end
  endtask

  task automatic test_multi_pe();
    logic [15:0] got = '0;
    int n = 0;
    bit seen = 0;
    baseC = 4'd0; startC = 1'b1; tick(); startC = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (doneC) begin seen = 1; break; end
      if (validC) begin
        if (n < 4) got[n*4 +: 4] = cellC;
        n++;
      end
      tick();
    end
    checks++;
    if (!seen || n != 4 || got !== 16'h3CA5) begin
      errors++; $display("[TB] FAIL multi_pe_beats got=%h n=%0d want=3ca5 n=4", got, n);
    end
  endtask

  // Hard stop in case any scenario wedges outside its own cycle bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy_start();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    test_multi_pe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
